// File: rtl/axis_skid_reg.sv
// Output register plus one-entry skid buffer for a single stream carrying
// data, last and a destination select. Ready towards the source is registered.
module axis_skid_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    input  logic [SEL_WIDTH-1:0]  i_sel,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [SEL_WIDTH-1:0]  o_sel,
    output logic                  o_valid,
    input  logic                  i_ready
);

    logic                  r_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;
    logic [SEL_WIDTH-1:0]  r_out_sel;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic [SEL_WIDTH-1:0]  r_skid_sel;
    logic                  w_ready_next;

    // Keep accepting while the skid slot is free, unless the output is already
    // full and another beat lands this cycle (that beat takes the skid slot).
    assign w_ready_next = i_ready || (!r_skid_valid && (!r_out_valid || !i_valid));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ready      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_sel    <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_sel   <= '0;
        end else begin
            r_ready <= w_ready_next;
            if (r_ready) begin
                if (i_ready || !r_out_valid) begin
                    r_out_valid <= i_valid;
                    r_out_data  <= i_data;
                    r_out_last  <= i_last;
                    r_out_sel   <= i_sel;
                end else begin
                    r_skid_valid <= i_valid;
                    r_skid_data  <= i_data;
                    r_skid_last  <= i_last;
                    r_skid_sel   <= i_sel;
                end
            end else if (i_ready) begin
                r_out_valid  <= r_skid_valid;
                r_out_data   <= r_skid_data;
                r_out_last   <= r_skid_last;
                r_out_sel    <= r_skid_sel;
                r_skid_valid <= 1'b0;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_last  = r_out_last;
    assign o_sel   = r_out_sel;

endmodule

// File: rtl/axis_select_demux.sv
// AXI4-Stream 1-to-M_COUNT frame demultiplexer: a binary select, latched at
// frame start, steers every beat of the frame to one master port.
// Handshake: a beat moves on any stream when valid and ready are both high
// at a rising clk edge; valid never waits on ready.
module axis_select_demux #(
    parameter int M_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    localparam int SEL_WIDTH = $clog2(M_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_tdata,
    input  logic                          s_tvalid,
    output logic                          s_tready,
    input  logic                          s_tlast,
    input  logic                          enable,
    input  logic                          drop,
    input  logic [SEL_WIDTH-1:0]          sel,
    output logic [M_COUNT*DATA_WIDTH-1:0] m_tdata,
    output logic [M_COUNT-1:0]            m_tvalid,
    input  logic [M_COUNT-1:0]            m_tready,
    output logic [M_COUNT-1:0]            m_tlast,
    output logic                          busy
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic [SEL_WIDTH-1:0]  w_sel_next;
    logic                  r_drop;
    logic                  w_drop_next;

    logic [SEL_WIDTH-1:0]  w_eff_sel;
    logic                  w_eff_drop;
    logic                  w_sel_oob;
    logic                  w_xfer;
    logic                  w_push;
    logic                  w_skid_ready;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic                  w_out_last;
    logic [SEL_WIDTH-1:0]  w_out_sel;
    logic                  w_out_ready;

    // An index past the last port is treated as a drop request.
    assign w_sel_oob = (32'(sel) >= 32'(M_COUNT));

    always_comb begin
        w_eff_sel  = sel;
        w_eff_drop = drop | w_sel_oob;
        if (r_state == ST_ACTIVE) begin
            w_eff_sel  = r_sel;
            w_eff_drop = r_drop;
        end
    end

    // Dropped beats bypass the buffer, so they are never throttled by it.
    assign s_tready = ((r_state == ST_ACTIVE) || enable) && (w_eff_drop || w_skid_ready);
    assign w_xfer   = s_tvalid && s_tready;
    assign w_push   = w_xfer && !w_eff_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_drop  <= w_drop_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_drop_next  = r_drop;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !s_tlast) begin
                    w_state_next = ST_ACTIVE;
                    w_sel_next   = sel;
                    w_drop_next  = w_eff_drop;
                end
            end
            ST_ACTIVE: begin
                if (w_xfer && s_tlast) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_ACTIVE);

    axis_skid_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (s_tdata),
        .i_last  (s_tlast),
        .i_sel   (w_eff_sel),
        .i_valid (w_push),
        .o_ready (w_skid_ready),
        .o_data  (w_out_data),
        .o_last  (w_out_last),
        .o_sel   (w_out_sel),
        .o_valid (w_out_valid),
        .i_ready (w_out_ready)
    );

    // Only the port that owns the buffered beat can drain it; the select travels
    // with the beat, so a later sel change cannot redirect it.
    always_comb begin
        w_out_ready = 1'b0;
        m_tvalid    = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (w_out_sel == SEL_WIDTH'(i)) begin
                w_out_ready = m_tready[i];
                m_tvalid[i] = w_out_valid;
            end
        end
    end

    assign m_tdata = {M_COUNT{w_out_data}};
    assign m_tlast = {M_COUNT{w_out_last}};

endmodule

// File: tb/tb_axis_select_demux.sv
// Directed bench for axis_select_demux: a 4-port instance checked through an
// expected-beat queue, plus a 3-port instance for out-of-range select.
module tb_axis_select_demux;

    logic        clk;
    logic        rst;

    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        enable;
    logic        drop;
    logic [1:0]  sel;
    logic [31:0] m_tdata;
    logic [3:0]  m_tvalid;
    logic [3:0]  m_tready;
    logic [3:0]  m_tlast;
    logic        busy;

    logic [7:0]  s3_tdata;
    logic        s3_tvalid;
    logic        s3_tready;
    logic        s3_tlast;
    logic        enable3;
    logic        drop3;
    logic [1:0]  sel3;
    logic [23:0] m3_tdata;
    logic [2:0]  m3_tvalid;
    logic [2:0]  m3_tready;
    logic [2:0]  m3_tlast;
    logic        busy3;

    int          checks;
    int          errors;
    int          cyc;

    // Entry layout: {port[1:0], last, data[7:0]}
    logic [10:0] exp_q[$];
    logic [10:0] mon_e;
    logic [1:0]  mon_p;

    bit          m_in_frame;
    logic [1:0]  m_fsel;
    bit          m_fdrop;

    axis_select_demux #(.M_COUNT(4), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .enable   (enable),
        .drop     (drop),
        .sel      (sel),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy     (busy)
    );

    axis_select_demux #(.M_COUNT(3), .DATA_WIDTH(8)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s3_tdata),
        .s_tvalid (s3_tvalid),
        .s_tready (s3_tready),
        .s_tlast  (s3_tlast),
        .enable   (enable3),
        .drop     (drop3),
        .sel      (sel3),
        .m_tdata  (m3_tdata),
        .m_tvalid (m3_tvalid),
        .m_tready (m3_tready),
        .m_tlast  (m3_tlast),
        .busy     (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one beat and holds it until accepted; returns cycles spent.
    task automatic send_beat(input logic [7:0] d, input logic l, output int n);
        logic       seen;
        bit         acc;
        logic [1:0] es;
        bit         ed;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        acc      = 0;
        n        = 0;
        while (!acc && n < 64) begin
            @(negedge clk);
            seen = s_tready;
            n++;
            @(posedge clk);
            #1;
            if (seen === 1'b1) acc = 1;
        end
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL accept_timeout observed=0 expected=1 data=%0h", d);
        end
        if (acc) begin
            if (m_in_frame) begin
                es = m_fsel;
                ed = m_fdrop;
            end else begin
                es = sel;
                ed = drop;
            end
            if (!ed) exp_q.push_back({es, l, d});
            m_in_frame = !l;
            m_fsel     = es;
            m_fdrop    = ed;
        end
    endtask

    task automatic idle_cycles(input int k);
        s_tvalid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && ((m_tvalid & m_tready) != 4'b0000)) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_beat observed=%0h expected=none", m_tvalid);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_p = mon_e[10:9];
                chk("out_valid", 32'(m_tvalid), 32'(4'(1) << mon_p));
                chk("out_data", 32'(m_tdata[mon_p*8 +: 8]), 32'(mon_e[7:0]));
                chk("out_last", 32'(m_tlast[mon_p]), 32'(mon_e[8]));
            end
        end
    end

    initial begin
        checks = 0; errors = 0;
        m_in_frame = 0; m_fsel = 2'd0; m_fdrop = 0;
        rst = 1'b1;
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0;
        enable = 1'b1; drop = 1'b0; sel = 2'd0; m_tready = 4'hF;
        s3_tdata = 8'h00; s3_tvalid = 1'b0; s3_tlast = 1'b0;
        enable3 = 1'b1; drop3 = 1'b0; sel3 = 2'd0; m3_tready = 3'b111;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'h0);
        chk("rst_s_tready", 32'(s_tready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst3_m_tvalid", 32'(m3_tvalid), 32'h0);
        rst = 1'b0;
        idle_cycles(2);

        // Single-beat frame to port 2
        sel = 2'd2;
        send_beat(8'hA5, 1'b1, cyc);
        chk("single_valid", 32'(m_tvalid), 32'h4);
        chk("single_data", 32'(m_tdata[23:16]), 32'hA5);
        chk("single_last", 32'(m_tlast[2]), 32'h1);
        chk("single_busy", 32'(busy), 32'h0);
        idle_cycles(2);

        // 4-beat frame; sel changes mid-frame and must be ignored
        sel = 2'd1;
        send_beat(8'h01, 1'b0, cyc);
        chk("frame_busy_b1", 32'(busy), 32'h1);
        sel = 2'd3;
        send_beat(8'h02, 1'b0, cyc);
        send_beat(8'h03, 1'b0, cyc);
        chk("frame_busy_b3", 32'(busy), 32'h1);
        send_beat(8'h04, 1'b1, cyc);
        chk("frame_busy_end", 32'(busy), 32'h0);
        idle_cycles(3);

        // Backpressure on port 0 for three cycles of a continuous stream
        sel = 2'd0;
        m_tready = 4'b1110;
        send_beat(8'h10, 1'b0, cyc);
        chk("bp_first_cyc", 32'(cyc), 32'd1);
        send_beat(8'h11, 1'b0, cyc);
        chk("bp_second_cyc", 32'(cyc), 32'd1);
        chk("bp_ready_low", 32'(s_tready), 32'h0);
        s_tdata = 8'h12;
        @(posedge clk);
        #1;
        m_tready = 4'hF;
        chk("bp_ready_still_low", 32'(s_tready), 32'h0);
        send_beat(8'h12, 1'b0, cyc);
        chk("bp_release_cyc", 32'(cyc), 32'd2);
        send_beat(8'h13, 1'b0, cyc);
        chk("bp_stream_cyc3", 32'(cyc), 32'd1);
        send_beat(8'h14, 1'b1, cyc);
        chk("bp_stream_cyc4", 32'(cyc), 32'd1);
        idle_cycles(4);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Dropped 3-beat frame, no port ready, then a real frame to port 3
        m_tready = 4'h0;
        drop = 1'b1;
        sel = 2'd2;
        send_beat(8'h21, 1'b0, cyc);
        chk("drop_cyc1", 32'(cyc), 32'd1);
        drop = 1'b0;
        send_beat(8'h22, 1'b0, cyc);
        chk("drop_cyc2", 32'(cyc), 32'd1);
        chk("drop_valid2", 32'(m_tvalid), 32'h0);
        send_beat(8'h23, 1'b1, cyc);
        chk("drop_cyc3", 32'(cyc), 32'd1);
        chk("drop_valid3", 32'(m_tvalid), 32'h0);
        m_tready = 4'hF;
        sel = 2'd3;
        send_beat(8'h24, 1'b1, cyc);
        chk("after_drop_valid", 32'(m_tvalid), 32'h8);
        chk("after_drop_data", 32'(m_tdata[31:24]), 32'h24);
        idle_cycles(2);

        // enable low in IDLE blocks the start; low mid-frame does not
        enable = 1'b0;
        sel = 2'd1;
        s_tvalid = 1'b1;
        s_tdata = 8'h30;
        s_tlast = 1'b0;
        @(negedge clk);
        chk("enable_low_ready", 32'(s_tready), 32'h0);
        @(posedge clk);
        #1;
        chk("enable_low_valid", 32'(m_tvalid), 32'h0);
        enable = 1'b1;
        send_beat(8'h31, 1'b0, cyc);
        enable = 1'b0;
        send_beat(8'h32, 1'b0, cyc);
        chk("enable_mid_cyc2", 32'(cyc), 32'd1);
        send_beat(8'h33, 1'b1, cyc);
        chk("enable_mid_cyc3", 32'(cyc), 32'd1);
        idle_cycles(2);
        enable = 1'b1;

        // Out-of-range select on the 3-port instance
        sel3 = 2'd3;
        s3_tvalid = 1'b1;
        s3_tdata = 8'h61;
        s3_tlast = 1'b0;
        @(negedge clk);
        chk("oob_ready1", 32'(s3_tready), 32'h1);
        @(posedge clk);
        #1;
        s3_tdata = 8'h62;
        s3_tlast = 1'b1;
        @(negedge clk);
        chk("oob_ready2", 32'(s3_tready), 32'h1);
        chk("oob_busy", 32'(busy3), 32'h1);
        chk("oob_valid1", 32'(m3_tvalid), 32'h0);
        @(posedge clk);
        #1;
        s3_tvalid = 1'b0;
        @(negedge clk);
        chk("oob_valid2", 32'(m3_tvalid), 32'h0);
        chk("oob_busy_end", 32'(busy3), 32'h0);
        @(posedge clk);
        #1;
        sel3 = 2'd2;
        s3_tvalid = 1'b1;
        s3_tdata = 8'h77;
        @(negedge clk);
        chk("p3_ready", 32'(s3_tready), 32'h1);
        @(posedge clk);
        #1;
        s3_tvalid = 1'b0;
        chk("p3_valid", 32'(m3_tvalid), 32'h4);
        chk("p3_data", 32'(m3_tdata[23:16]), 32'h77);
        enable3 = 1'b0;
        s3_tvalid = 1'b1;
        @(negedge clk);
        chk("p3_enable_low", 32'(s3_tready), 32'h0);
        @(posedge clk);
        #1;
        s3_tvalid = 1'b0;

        // Reset mid-frame with two beats buffered on a stalled port
        sel = 2'd2;
        m_tready = 4'b1011;
        send_beat(8'h51, 1'b0, cyc);
        send_beat(8'h52, 1'b0, cyc);
        chk("mid_busy", 32'(busy), 32'h1);
        chk("mid_ready_low", 32'(s_tready), 32'h0);
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_in_frame = 0;
        chk("mid_rst_valid", 32'(m_tvalid), 32'h0);
        chk("mid_rst_ready", 32'(s_tready), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        m_tready = 4'hF;
        sel = 2'd1;
        send_beat(8'h5F, 1'b1, cyc);
        chk("post_rst_valid", 32'(m_tvalid), 32'h2);
        chk("post_rst_data", 32'(m_tdata[15:8]), 32'h5F);
        idle_cycles(4);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
